// File: rtl/memory_stage.sv
// Memory pipeline stage: data memory, memory-mapped HEX/LEDR registers and
// the registered hand-off of execute results to writeback.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef OP_LDW
`define OP_LDW 8'h12
`endif
`ifndef OP_STW
`define OP_STW 8'h13
`endif

module memory_stage #(
  parameter int                     DMEM_DEPTH = 1024,
  parameter logic [`REG_WIDTH-1:0]  ADDR_HEX   = 32'hFFFFFFF0,
  parameter logic [`REG_WIDTH-1:0]  ADDR_LEDR  = 32'hFFFFFFF4
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic [`OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [`REG_WIDTH-1:0]    I_ALUOut,
  input  logic [`REG_WIDTH-1:0]    I_StoreData,
  input  logic [3:0]               I_DestRegIdx,
  input  logic                     I_FetchStall,
  input  logic                     I_DepStall,
  output logic [`OPCODE_WIDTH-1:0] O_Opcode,
  output logic [`REG_WIDTH-1:0]    O_ALUOut,
  output logic [`REG_WIDTH-1:0]    O_MemOut,
  output logic [3:0]               O_DestRegIdx,
  output logic                     O_FetchStall,
  output logic                     O_DepStall,
  output logic [15:0]              O_HEX,
  output logic [9:0]               O_LEDR
);

  localparam int IDX_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [`REG_WIDTH-1:0]    mem_q [DMEM_DEPTH];
  logic [`OPCODE_WIDTH-1:0] opcode_q;
  logic [`REG_WIDTH-1:0]    aluout_q;
  logic [`REG_WIDTH-1:0]    memout_q;
  logic [`REG_WIDTH-1:0]    memout_d;
  logic [3:0]               dest_q;
  logic                     fetch_stall_q;
  logic                     dep_stall_q;
  logic [15:0]              hex_q;
  logic [9:0]               ledr_q;

  logic [IDX_W-1:0] idx;
  logic             active;
  logic             is_hex;
  logic             is_ledr;
  logic             is_load;
  logic             is_store;
  logic             mem_we;

  // Upper address bits are dropped so non-IO accesses wrap modulo the depth.
  assign idx      = I_ALUOut[IDX_W-1:0];
  assign active   = I_LOCK && !I_RESET && !I_FetchStall && !I_DepStall;
  assign is_hex   = (I_ALUOut == ADDR_HEX);
  assign is_ledr  = (I_ALUOut == ADDR_LEDR);
  assign is_load  = active && (I_Opcode == `OP_LDW);
  assign is_store = active && (I_Opcode == `OP_STW);
  assign mem_we   = is_store && !is_hex && !is_ledr;

  always_comb begin
    memout_d = '0;
    if (is_load) begin
      if (is_hex)       memout_d = {{(`REG_WIDTH-16){1'b0}}, hex_q};
      else if (is_ledr) memout_d = {{(`REG_WIDTH-10){1'b0}}, ledr_q};
      else              memout_d = mem_q[idx];
    end
  end

  // Memory has no reset so its contents survive a pipeline reset.
  always_ff @(posedge I_CLOCK) begin
    if (mem_we) mem_q[idx] <= I_StoreData;
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      opcode_q      <= '0;
      aluout_q      <= '0;
      memout_q      <= '0;
      dest_q        <= '0;
      fetch_stall_q <= 1'b1;
      dep_stall_q   <= 1'b0;
      hex_q         <= '0;
      ledr_q        <= '0;
    end else if (I_LOCK) begin
      opcode_q      <= I_Opcode;
      aluout_q      <= I_ALUOut;
      memout_q      <= memout_d;
      dest_q        <= I_DestRegIdx;
      fetch_stall_q <= I_FetchStall;
      dep_stall_q   <= I_DepStall;
      if (is_store && is_hex)  hex_q  <= I_StoreData[15:0];
      if (is_store && is_ledr) ledr_q <= I_StoreData[9:0];
    end
  end

  assign O_Opcode     = opcode_q;
  assign O_ALUOut     = aluout_q;
  assign O_MemOut     = memout_q;
  assign O_DestRegIdx = dest_q;
  assign O_FetchStall = fetch_stall_q;
  assign O_DepStall   = dep_stall_q;
  assign O_HEX        = hex_q;
  assign O_LEDR       = ledr_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random traffic checked
// against a behavioural model of memory, IO registers and pipeline outputs.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef OP_LDW
`define OP_LDW 8'h12
`endif
`ifndef OP_STW
`define OP_STW 8'h13
`endif

module tb_memory_stage;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] A_HEX = 32'hFFFFFFF0;
  localparam logic [31:0] A_LED = 32'hFFFFFFF4;
  localparam logic [7:0]  LDW   = `OP_LDW;
  localparam logic [7:0]  STW   = `OP_STW;
  localparam logic [7:0]  ADD   = 8'h01;

  logic        clk = 1'b0;
  logic        rst, lock, fs_i, ds_i;
  logic [7:0]  op_i;
  logic [31:0] alu_i, sd_i;
  logic [3:0]  dst_i;
  logic [7:0]  op_o;
  logic [31:0] alu_o, mem_o;
  logic [3:0]  dst_o;
  logic        fs_o, ds_o;
  logic [15:0] hex_o;
  logic [9:0]  led_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] m_mem [int];
  logic [15:0] m_hex;
  logic [9:0]  m_led;
  logic [7:0]  e_op;
  logic [31:0] e_alu, e_mem;
  logic        e_mem_known;
  logic [3:0]  e_dst;
  logic        e_fs, e_ds;
  logic [32:0] exp_q[$];

  memory_stage #(.DMEM_DEPTH(DEPTH), .ADDR_HEX(A_HEX), .ADDR_LEDR(A_LED)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_Opcode(op_i),
    .I_ALUOut(alu_i), .I_StoreData(sd_i), .I_DestRegIdx(dst_i),
    .I_FetchStall(fs_i), .I_DepStall(ds_i),
    .O_Opcode(op_o), .O_ALUOut(alu_o), .O_MemOut(mem_o), .O_DestRegIdx(dst_o),
    .O_FetchStall(fs_o), .O_DepStall(ds_o), .O_HEX(hex_o), .O_LEDR(led_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a % 32'(DEPTH));
  endfunction

  // One clock of stimulus: update the model from the spec rules, then compare.
  task automatic step(input logic r, input logic lk, input logic [7:0] op,
                      input logic [31:0] alu, input logic [31:0] sd,
                      input logic [3:0] dst, input logic fs, input logic ds);
    logic act;
    logic [32:0] e;
    rst = r; lock = lk; op_i = op; alu_i = alu; sd_i = sd;
    dst_i = dst; fs_i = fs; ds_i = ds;
    act = lk && !r && !fs && !ds;
    if (r) begin
      e_op = '0; e_alu = '0; e_mem = '0; e_mem_known = 1'b1; e_dst = '0;
      e_fs = 1'b1; e_ds = 1'b0; m_hex = '0; m_led = '0;
    end else if (lk) begin
      e_op = op; e_alu = alu; e_dst = dst; e_fs = fs; e_ds = ds;
      e_mem = '0; e_mem_known = 1'b1;
      if (act && op == LDW) begin
        if (alu == A_HEX)                  e_mem = {16'h0, m_hex};
        else if (alu == A_LED)             e_mem = {22'h0, m_led};
        else if (m_mem.exists(widx(alu)))  e_mem = m_mem[widx(alu)];
        else                               e_mem_known = 1'b0;
      end
      if (act && op == STW) begin
        if (alu == A_HEX)      m_hex = sd[15:0];
        else if (alu == A_LED) m_led = sd[9:0];
        else                   m_mem[widx(alu)] = sd;
      end
    end
    exp_q.push_back({e_mem_known, e_mem});
    @(posedge clk);
    #1;
    check("opcode", {24'h0, op_o}, {24'h0, e_op});
    check("aluout", alu_o, e_alu);
    check("dest", {28'h0, dst_o}, {28'h0, e_dst});
    check("fetch_stall", {31'h0, fs_o}, {31'h0, e_fs});
    check("dep_stall", {31'h0, ds_o}, {31'h0, e_ds});
    check("hex", {16'h0, hex_o}, {16'h0, m_hex});
    check("ledr", {22'h0, led_o}, {22'h0, m_led});
    e = exp_q.pop_front();
    if (e[32]) check("memout", mem_o, e[31:0]);
  endtask

  task automatic run(input logic [7:0] op, input logic [31:0] alu, input logic [31:0] sd);
    step(1'b0, 1'b1, op, alu, sd, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0, 1:    return 32'($urandom_range(0, 15));
      2:       return 32'($urandom_range(0, 15)) + 32'(DEPTH) * 32'($urandom_range(1, 7));
      3:       return A_HEX;
      4:       return A_LED;
      5:       return 32'h0000_03F0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; lock = 1'b0; op_i = '0; alu_i = '0; sd_i = '0;
    dst_i = '0; fs_i = 1'b0; ds_i = 1'b0;
    m_hex = '0; m_led = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with lock low to show reset wins.
    step(1'b1, 1'b0, STW, 32'd7, 32'h55, 4'd3, 1'b0, 1'b0);

    // Store then immediately load the same address.
    run(STW, 32'd8, 32'hDEADBEEF);
    run(LDW, 32'd8, 32'h0);
    run(ADD, 32'd1, 32'h0);

    // Reset aborts an active store to address 5.
    run(STW, 32'd5, 32'h0000_1111);
    step(1'b1, 1'b1, STW, 32'd5, 32'h2222_2222, 4'd9, 1'b0, 1'b0);
    run(LDW, 32'd5, 32'h0);

    // IO stores leave the aliased memory word alone.
    run(STW, 32'h0000_03F0, 32'hCAFE_F00D);
    run(STW, A_HEX, 32'h1234ABCD);
    run(STW, A_LED, 32'h0000_03FF);
    run(LDW, 32'h0000_03F0, 32'h0);
    run(LDW, A_HEX, 32'h0);
    run(LDW, A_LED, 32'h0);

    // Stalled store is suppressed but stall flags propagate.
    run(STW, 32'd3, 32'h0000_3333);
    step(1'b0, 1'b1, STW, 32'd3, 32'h4444_4444, 4'd2, 1'b0, 1'b1);
    step(1'b0, 1'b1, STW, A_HEX, 32'h0000_9999, 4'd2, 1'b1, 1'b0);
    step(1'b0, 1'b1, LDW, 32'd3, 32'h0, 4'd2, 1'b0, 1'b1);
    run(LDW, 32'd3, 32'h0);

    // Lock low holds everything for three cycles.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, (i == 0) ? STW : LDW, rand_addr(), $urandom,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run(LDW, 32'd3, 32'h0);

    // Load wraps modulo depth.
    run(STW, 32'd2, 32'h0BAD_F00D);
    run(LDW, 32'(DEPTH + 2), 32'h0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] op;
      case ($urandom_range(0, 4))
        0, 1:    op = STW;
        2, 3:    op = LDW;
        default: op = 8'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 6) != 0), op, rand_addr(),
           $urandom, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameters: DMEM_DEPTH, default 1024, data-memory words; ADDR_HEX, default 32'hFFFFFFF0, HEX register address; ADDR_LEDR, default 32'hFFFFFFF4, LEDR register address.
REQ-002 SHALL have ports:
- I_CLOCK  in  1  sole clock, rising edge
- I_RESET  in  1  synchronous, active-high reset
- I_LOCK  in  1  pipeline enable; 0 = hold
- I_Opcode  in  `OPCODE_WIDTH  opcode from execute
- I_ALUOut  in  `REG_WIDTH  ALU result / effective address
- I_StoreData  in  `REG_WIDTH  store source value
- I_DestRegIdx  in  4  destination register
- I_FetchStall  in  1  fetch-stall bubble flag
- I_DepStall  in  1  dependency-stall bubble flag
- O_Opcode  out  `OPCODE_WIDTH  to writeback
- O_ALUOut  out  `REG_WIDTH  to writeback
- O_MemOut  out  `REG_WIDTH  load data to writeback
- O_DestRegIdx  out  4  to writeback
- O_FetchStall  out  1  to writeback
- O_DepStall  out  1  to writeback
- O_HEX  out  16  memory-mapped 7-seg value
- O_LEDR  out  10  memory-mapped LED value
REQ-003 SHALL have one clock and synchronous active-high reset, ports I_CLOCK and I_RESET.

Function
REQ-004 SHALL contain a DMEM_DEPTH x `REG_WIDTH data memory, word index = I_ALUOut[log2(DMEM_DEPTH)-1:0]; read is combinational, write on rising I_CLOCK.
REQ-005 SHALL register all O_ pipeline outputs; latency from inputs to O_ outputs is exactly 1 cycle.
REQ-006 SHALL, when I_LOCK=1 and I_RESET=0, latch O_Opcode, O_ALUOut, O_DestRegIdx, O_FetchStall, O_DepStall from the corresponding inputs each cycle.
REQ-007 SHALL define "active" = I_LOCK=1, I_RESET=0, I_FetchStall=0, I_DepStall=0.
REQ-008 SHALL, for active `OP_LDW: O_MemOut <= mem[index] if I_ALUOut not an IO address; {16'h0,HEX} if I_ALUOut==ADDR_HEX; {22'h0,LEDR} if I_ALUOut==ADDR_LEDR.
REQ-009 SHALL, for active `OP_STW: I_ALUOut==ADDR_HEX -> HEX <= I_StoreData[15:0]; ==ADDR_LEDR -> LEDR <= I_StoreData[9:0]; otherwise mem[index] <= I_StoreData; IO stores never modify memory.
REQ-010 SHALL set O_MemOut <= 0 for any non-load opcode or when not active.
REQ-011 SHALL suppress all memory and IO-register writes when I_FetchStall=1 or I_DepStall=1; stall flags still propagate per REQ-006.
REQ-012 SHALL, when I_LOCK=0 and I_RESET=0, hold every register (pipeline outputs, HEX, LEDR, memory).
REQ-013 SHALL ignore upper address bits above the index for non-IO addresses (wrap modulo DMEM_DEPTH).
REQ-014 SHALL drive O_HEX/O_LEDR continuously from the HEX/LEDR registers; a store is visible on them the cycle after its edge.
REQ-015 SHALL give a load immediately following a store to the same address the stored value (write committed on prior edge).

Reset
REQ-016 SHALL, on a rising edge with I_RESET=1, clear O_Opcode, O_ALUOut, O_MemOut, O_DestRegIdx, HEX, LEDR to 0 and set O_FetchStall=1, O_DepStall=0, regardless of I_LOCK.
REQ-017 SHALL not clear data memory on reset; contents are preserved across reset.
REQ-018 SHALL abort any store presented in a reset cycle (no memory/IO write).

Verification
REQ-019 SHALL cover: reset asserted mid-stream with active STW to addr 5 -> mem[5] unchanged, outputs as REQ-016 next cycle.
REQ-020 SHALL cover: STW data 32'hDEADBEEF addr 8, then LDW addr 8 -> O_MemOut=32'hDEADBEEF one cycle after the load.
REQ-021 SHALL cover: STW 32'h1234ABCD to ADDR_HEX, STW 32'h3FF to ADDR_LEDR -> O_HEX=16'hABCD, O_LEDR=10'h3FF; mem[ADDR_HEX index] unchanged.
REQ-022 SHALL cover: STW with I_DepStall=1 to addr 3 -> mem[3], HEX, LEDR unchanged; O_DepStall=1 next cycle, O_MemOut=0.
REQ-023 SHALL cover: I_LOCK=0 for 3 cycles with varying inputs -> all outputs hold prior values.
REQ-024 SHALL cover: LDW at address DMEM_DEPTH+2 -> returns mem[2] (wrap).
